exe_div: RTL and testbench

- Iterative 32-bit divider in the EXE stage, fed by the ID/EXE pipeline register outputs (operands `o_da` / `o_db`, decoded DIV/DIVU control).
- Computes quotient and remainder for MIPS DIV/DIVU. Results go to HI/LO write-back.
- Raises a stall request to the pipeline stall controller until the result is ready.
- Supports cancellation on exception flush.

---
 rtl/exe_div.sv | 168 ++++++++++++++++
 tb/tb_exe_div.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_div.sv
// Iterative restoring divider for MIPS DIV/DIVU in the EXE stage.
// One quotient bit per cycle; raises a stall request until the result is registered.
module exe_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_cancel,
    output logic             o_stall_req,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StDivZero,
        StCalc,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             sgn_q, sgn_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dvs_q, neg_dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             in_dvd_neg;
    logic             in_dvs_neg;
    logic [WIDTH-1:0] in_dvd_mag;
    logic [WIDTH-1:0] in_dvs_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             last_step;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        in_dvd_neg = i_signed & i_dividend[WIDTH-1];
        in_dvs_neg = i_signed & i_divisor[WIDTH-1];
        in_dvd_mag = in_dvd_neg ? -i_dividend : i_dividend;
        in_dvs_mag = in_dvs_neg ? -i_divisor : i_divisor;
    end

    // Restoring step: the partial remainder stays below the divisor, so WIDTH+1 bits
    // hold the shifted value and the sign of the trial subtraction.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_sub[WIDTH];
        rem_step  = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], q_bit};
        q_fix     = (sgn_q & (neg_dvd_q ^ neg_dvs_q)) ? -quo_step : quo_step;
        r_fix     = (sgn_q & neg_dvd_q) ? -rem_step : rem_step;
        last_step = (cnt_q == CntW'(WIDTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        sgn_d       = sgn_q;
        neg_dvd_d   = neg_dvd_q;
        neg_dvs_d   = neg_dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            StIdle: begin
                if (i_start && !i_cancel) begin
                    dvd_d     = in_dvd_mag;
                    dvs_d     = in_dvs_mag;
                    sgn_d     = i_signed;
                    neg_dvd_d = in_dvd_neg;
                    neg_dvs_d = in_dvs_neg;
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    state_d   = (i_divisor == '0) ? StDivZero : StCalc;
                end
            end
            StDivZero: begin
                quotient_d  = '0;
                remainder_d = '0;
                state_d     = StDone;
            end
            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    state_d     = StDone;
                end
            end
            StDone: begin
                // i_start is ignored here so the instruction still in EXE does not restart.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (i_cancel) begin
            state_d     = StIdle;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            sgn_q       <= 1'b0;
            neg_dvd_q   <= 1'b0;
            neg_dvs_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            sgn_q       <= sgn_d;
            neg_dvd_q   <= neg_dvd_d;
            neg_dvs_q   <= neg_dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Stall drops in DONE so the pipeline advances on the DONE edge.
    assign o_stall_req = ~i_cancel & (((state_q == StIdle) & i_start) |
                                      (state_q == StCalc) | (state_q == StDivZero));
    assign o_busy      = (state_q != StIdle);
    assign o_valid     = (state_q == StDone);
    assign o_quotient  = quotient_q;
    assign o_remainder = remainder_q;

endmodule

// File: tb/tb_exe_div.sv
// Scoreboard bench for exe_div: driver pushes model results, a negedge monitor pops on o_valid.
module tb_exe_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_cancel;
    logic        o_stall_req;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    exe_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_cancel   (i_cancel),
        .o_stall_req(o_stall_req),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // MIPS semantics via wide integer arithmetic: truncating division, remainder
    // takes the dividend's sign, divide by zero yields zeros.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = {32'd0, a};
            y = {32'd0, b};
        end
        q = x / y;
        r = x % y;
        return {q[31:0], r[31:0]};
    endfunction

    always @(negedge clk) begin
        if (o_valid) begin
            n_valid++;
            check("stall_in_done", {31'd0, o_stall_req}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("quotient", o_quotient, e[63:32]);
                check("remainder", o_remainder, e[31:0]);
                last_q = e[63:32];
                last_r = e[31:0];
            end
        end
    end

    // Issues one divide and waits for its o_valid; cycle 0 is the accept cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input bit hold, output int stalls, output int lat);
        bit got;
        @(posedge clk);
        #1;
        i_cancel   = 1'b0;
        i_start    = 1'b1;
        i_signed   = s;
        i_dividend = a;
        i_divisor  = b;
        exp_q.push_back(model(a, b, s));
        stalls = 0;
        lat    = -1;
        got    = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1'b1;
                lat = c;
            end else if (o_stall_req) begin
                stalls++;
            end
        end
        if (!got) check("valid_timeout", 32'd0, 32'd1);
        if (!hold) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
    endtask

    task automatic timed_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input bit hold);
        int st, lt;
        run_div(a, b, s, hold, st, lt);
        check("latency", lt, (b == 32'd0) ? 32'd2 : 32'd33);
        check("stall_cycles", st, (b == 32'd0) ? 32'd2 : 32'd33);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          nv0;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          nv0, st, lt;

        reset      = 1'b0;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = 32'd0;
        i_divisor  = 32'd0;
        i_cancel   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_quotient", o_quotient, 32'd0);
        check("rst_remainder", o_remainder, 32'd0);
        reset = 1'b1;

        // Directed cases, including sign and boundary corners.
        timed_div(32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
        check("q_100_7", o_quotient, 32'h0000000E);
        timed_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        timed_div(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        timed_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("q_min_neg1", o_quotient, 32'h80000000);
        timed_div(32'h80000000, 32'd1, 1'b1, 1'b0);
        timed_div(32'd5, 32'd0, 1'b0, 1'b0);
        check("q_div0", o_quotient, 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF - $urandom_range(0, 14);
                3:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            timed_div(a, b, s, 1'b0);
        end

        // Cancel mid-CALC, then restart in the following cycle.
        @(posedge clk);
        #1;
        i_start    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        i_cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall", {31'd0, o_stall_req}, 32'd0);
        check("cancel_q_hold", o_quotient, last_q);
        check("cancel_r_hold", o_remainder, last_r);
        timed_div(32'd9, 32'd3, 1'b0, 1'b0);

        // Back-to-back with i_start held through DONE.
        nv0 = n_valid;
        run_div(32'd20, 32'd6, 1'b0, 1'b1, st, lt);
        run_div(32'd21, 32'd5, 1'b0, 1'b0, st, lt);
        check("b2b_stalls", st, 32'd33);
        check("b2b_latency", lt, 32'd33);
        repeat (5) @(negedge clk);
        check("b2b_pulses", n_valid - nv0, 32'd2);

        // Reset during CALC.
        nv0 = n_valid;
        @(posedge clk);
        #1;
        i_start    = 1'b1;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        reset   = 1'b0;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_q", o_quotient, 32'd0);
        check("mid_rst_r", o_remainder, 32'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_no_valid", n_valid - nv0, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
